// File: rtl/alu_mul_sequencer_if.sv
// Bundle of the multiply request/response handshake, the main datapath's ALU request,
// and the shared ALU connection that alu_mul_sequencer arbitrates.
interface alu_mul_sequencer_if #(
    parameter int word_len = 32
);
    logic                start;
    logic [word_len-1:0] op_a;
    logic [word_len-1:0] op_b;
    logic                busy;
    logic                done;
    logic [word_len-1:0] product;

    logic [word_len-1:0] dp_in1;
    logic [word_len-1:0] dp_in2;
    logic [1:0]          dp_op;
    logic                dp_stall;

    logic [word_len-1:0] alu_in1;
    logic [word_len-1:0] alu_in2;
    logic [1:0]          alu_op;
    logic [word_len-1:0] alu_result;

    // The sequencer side.
    modport slave (
        input  start, op_a, op_b, dp_in1, dp_in2, dp_op, alu_result,
        output busy, done, product, dp_stall, alu_in1, alu_in2, alu_op
    );

    // The controller/datapath/ALU side.
    modport master (
        output start, op_a, op_b, dp_in1, dp_in2, dp_op, alu_result,
        input  busy, done, product, dp_stall, alu_in1, alu_in2, alu_op
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU for every accumulate step
// and hands the ALU back to the main datapath whenever it is not iterating.
module alu_mul_sequencer #(
    parameter int word_len = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_mul_sequencer_if.slave   bus
);
    localparam int cnt_w = $clog2(word_len) + 1;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [word_len-1:0] mcand;
    logic [word_len-1:0] mplier;
    logic [word_len-1:0] acc;
    logic [word_len-1:0] acc_nxt;
    logic [word_len-1:0] product_q;
    logic [cnt_w-1:0]    count;
    logic                last_iter;

    assign last_iter = (state == ITER) && (count == cnt_w'(word_len - 1));
    assign acc_nxt   = mplier[0] ? bus.alu_result : acc;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ITER;
            ITER:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.alu_in1 = bus.dp_in1;
        bus.alu_in2 = bus.dp_in2;
        bus.alu_op  = bus.dp_op;
        case (state)
            ITER: begin
                bus.busy    = 1'b1;
                bus.alu_in1 = acc;
                bus.alu_in2 = mcand;
                bus.alu_op  = ALU_ADD;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.dp_stall = bus.busy;
    assign bus.product  = product_q;

    // NOTE: these are plain registers, not a memory array, so all of them are cleared
    // by the asynchronous reset; an abort mid-operation therefore also clears product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mcand  <= bus.op_a;
                    mplier <= bus.op_b;
                    acc    <= '0;
                    count  <= '0;
                end
                ITER: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // The final step's accumulate must reach product on the same edge.
                    if (last_iter) product_q <= acc_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed self-checking bench for alu_mul_sequencer with a behavioural 4-op ALU model.
module tb_alu_mul_sequencer;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_mul_sequencer_if #(.word_len(W)) bus ();

    alu_mul_sequencer #(.word_len(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: add=0, sub=1, and=2, or=3.
    always_comb begin
        case (bus.alu_op)
            2'd0:    bus.alu_result = bus.alu_in1 + bus.alu_in2;
            2'd1:    bus.alu_result = bus.alu_in1 - bus.alu_in2;
            2'd2:    bus.alu_result = bus.alu_in1 & bus.alu_in2;
            default: bus.alu_result = bus.alu_in1 | bus.alu_in2;
        endcase
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a multiply and follow it to completion; inject>0 re-pulses start at that busy cycle.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp, input int inject, input string tag);
        int busy_cnt;
        int bad;
        int acc_moved;
        int extra_done;
        busy_cnt   = 0;
        bad        = 0;
        acc_moved  = 0;
        extra_done = 0;
        bus.dp_in1 = 32'h0000_0011;
        bus.dp_in2 = 32'h0000_0101;
        bus.dp_op  = 2'd2;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        #1;
        check({tag, " idle_dp_op_with_start"}, {30'd0, bus.alu_op}, 32'd2);
        tick();
        bus.start = 1'b0;
        bus.op_a  = 32'hDEAD_BEEF;
        bus.op_b  = 32'hCAFE_F00D;
        check({tag, " first_iter_alu_in2"}, bus.alu_in2, a);
        while (bus.busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (bus.alu_op !== 2'd0 || bus.dp_stall !== 1'b1 || bus.done !== 1'b0) bad++;
            if (bus.alu_in1 !== '0) acc_moved++;
            if (busy_cnt == inject) begin
                bus.op_a  = 32'd3;
                bus.op_b  = 32'd3;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        check({tag, " busy_cycles"}, busy_cnt, 32'd32);
        check({tag, " iter_outputs_bad"}, bad, 32'd0);
        if (b == '0) check({tag, " acc_updates"}, acc_moved, 32'd0);
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " product"}, bus.product, exp);
        check({tag, " dp_stall_in_done"}, {31'd0, bus.dp_stall}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra_done++;
        end
        check({tag, " no_extra_done_or_busy"}, extra_done, 32'd0);
        check({tag, " product_held"}, bus.product, exp);
    endtask

    initial begin
        int spurious;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.dp_in1 = '0;
        bus.dp_in2 = '0;
        bus.dp_op  = 2'd0;
        #12;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset product", bus.product, 32'd0);
        check("reset dp_stall", {31'd0, bus.dp_stall}, 32'd0);
        check("reset alu_op", {30'd0, bus.alu_op}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Idle pass-through: 5 - 7.
        bus.dp_in1 = 32'd5;
        bus.dp_in2 = 32'd7;
        bus.dp_op  = 2'd1;
        #1;
        check("pass alu_in1", bus.alu_in1, 32'd5);
        check("pass alu_in2", bus.alu_in2, 32'd7);
        check("pass alu_op", {30'd0, bus.alu_op}, 32'd1);
        check("pass alu_result", bus.alu_result, 32'hFFFF_FFFE);
        tick();

        run_mul(32'd6, 32'd7, 32'd42, 0, "mul6x7");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, "mulmax");
        run_mul(32'h1234_5678, 32'd0, 32'd0, 0, "mulzero");
        run_mul(32'd6, 32'd7, 32'd42, 10, "mulinject");

        // Abort 6*7 with reset at iteration 15.
        bus.dp_op = 2'd2;
        bus.op_a  = 32'd6;
        bus.op_b  = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("abort busy_before", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort product", bus.product, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort alu_op", {30'd0, bus.alu_op}, 32'd2);
        tick();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
        end
        check("abort no_done", spurious, 32'd0);
        run_mul(32'd9, 32'd9, 32'd81, 0, "mul9x9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
